uart_rx_row_loader: RTL and testbench

- Receive end of the serial link that the bench-side uart_tx drives: 8N1 UART receiver plus packet framer that loads the LED panel frame buffer one row at a time.
- Sits inside the panel top, between the uart_data pin and the frame-buffer write port.
- Sync byte, then row index, then ROW_BYTES payload bytes, then one row-wide write strobe.

---
 rtl/uart_rx_pkg.sv | 28 ++
 rtl/uart_rx_core.sv | 135 +++++++++++++
 rtl/uart_rx_row_loader.sv | 92 +++++++++
 tb/tb_uart_rx_row_loader.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the UART row loader.
// State enums, default sync marker and counter width helper.
package uart_rx_pkg;

  localparam logic [7:0] SYNC_BYTE_DFLT = 8'hA5;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
`ifdef UART_RX_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP,
    RX_RESYNC
  } rx_state_t;

  typedef enum logic [1:0] {
    FR_HUNT,
    FR_ROW,
    FR_DATA
  } fr_state_t;

  function automatic int clog2w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: 2-flop synchronizer plus bit-centre sampling FSM.
// Ports: clk, reset, uart_data in; rx_dv, rx_byte, rx_err out.
// UART_RX_PARITY_EN adds an even-parity bit between data and stop.
module uart_rx_core
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_data,
  output logic       rx_dv,
  output logic [7:0] rx_byte,
  output logic       rx_err
);

  localparam int CW = clog2w(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  logic            s1, s2;
  rx_state_t       st;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;
  logic            stop_ok;

`ifdef UART_RX_PARITY_EN
  logic par_q;
  assign stop_ok = s2 && ((^shift) == par_q);
`else
  assign stop_ok = s2;
`endif

  // Line idles high, so the synchronizer resets to 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= uart_data;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st      <= RX_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      rx_dv   <= 1'b0;
      rx_byte <= '0;
      rx_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      rx_dv  <= 1'b0;
      rx_err <= 1'b0;
      unique case (st)
        RX_IDLE: begin
          if (!s2) begin
            st      <= RX_START;
            cnt     <= '0;
            bit_idx <= '0;
          end
        end
        RX_START: begin
          if (cnt == HALF_M1) begin
            cnt <= '0;
            st  <= s2 ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == FULL_M1) begin
            cnt     <= '0;
            shift   <= {s2, shift[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              st <= RX_PARITY;
`else
              st <= RX_STOP;
`endif
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        RX_PARITY: begin
          if (cnt == FULL_M1) begin
            cnt   <= '0;
            par_q <= s2;
            st    <= RX_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        RX_STOP: begin
          if (cnt == FULL_M1) begin
            cnt <= '0;
            if (stop_ok) begin
              rx_dv   <= 1'b1;
              rx_byte <= shift;
              st      <= RX_IDLE;
            end else begin
              rx_err <= 1'b1;
              st     <= RX_RESYNC;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_RESYNC: begin
          // Need a full bit time of continuous idle before rearming.
          if (!s2) begin
            cnt <= '0;
          end else if (cnt == FULL_M1) begin
            cnt <= '0;
            st  <= RX_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: st <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_row_loader.sv
// UART receiver plus packet framer: SYNC, row index, ROW_BYTES payload.
// Ports: clk, reset, uart_data in; rx_dv/rx_byte/rx_err, fb_we/fb_row/fb_data out.
// Optional macro UART_RX_PARITY_EN enables even parity in the receiver.
module uart_rx_row_loader
  import uart_rx_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 20,
  parameter int         ROWS         = 8,
  parameter int         ROW_BYTES    = 4,
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DFLT
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         uart_data,
  output logic                         rx_dv,
  output logic [7:0]                   rx_byte,
  output logic                         rx_err,
  output logic                         fb_we,
  output logic [clog2w(ROWS)-1:0]      fb_row,
  output logic [8*ROW_BYTES-1:0]       fb_data
);

  localparam int RW = clog2w(ROWS);
  localparam int BW = clog2w(ROW_BYTES);
  localparam int DW = 8 * ROW_BYTES;

  uart_rx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_core (
    .clk      (clk),
    .reset    (reset),
    .uart_data(uart_data),
    .rx_dv    (rx_dv),
    .rx_byte  (rx_byte),
    .rx_err   (rx_err)
  );

  fr_state_t      fst;
  logic [BW-1:0]  lane;
  logic [RW-1:0]  row_q;
  logic [DW-1:0]  pay_q;
  logic [DW-1:0]  pay_nx;

  always_comb begin
    pay_nx = pay_q;
    pay_nx[8*lane +: 8] = rx_byte;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fst     <= FR_HUNT;
      lane    <= '0;
      row_q   <= '0;
      pay_q   <= '0;
      fb_we   <= 1'b0;
      fb_row  <= '0;
      fb_data <= '0;
    end else begin
      fb_we <= 1'b0;
      if (rx_err) begin
        fst <= FR_HUNT;
      end else if (rx_dv) begin
        unique case (fst)
          FR_HUNT: begin
            if (rx_byte == SYNC_BYTE) fst <= FR_ROW;
          end
          FR_ROW: begin
            if (32'(rx_byte) < ROWS) begin
              row_q <= rx_byte[RW-1:0];
              lane  <= '0;
              fst   <= FR_DATA;
            end else begin
              fst <= FR_HUNT;
            end
          end
          FR_DATA: begin
            pay_q <= pay_nx;
            lane  <= lane + 1'b1;
            if (lane == BW'(ROW_BYTES - 1)) begin
              fb_we   <= 1'b1;
              fb_row  <= row_q;
              fb_data <= pay_nx;
              fst     <= FR_HUNT;
            end
          end
          default: fst <= FR_HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_row_loader.sv
// Randomized scoreboard bench for uart_rx_row_loader.
// Serial driver feeds a packet-level model; a monitor pops expectations.
module tb_uart_rx_row_loader;

  localparam int CLKS = 20;
  localparam int ROWS = 8;
  localparam int RB   = 4;
  localparam logic [7:0] SYNC = 8'hA5;
`ifdef UART_RX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  // stop-bit centre is (NB-0.5) bit times after the start edge,
  // plus 2 synchronizer cycles and 1 registered-output cycle
  localparam int LAT = (CLKS * (2 * NB - 1)) / 2 + 3;

  logic        clk, reset, uart_data;
  logic        rx_dv, rx_err, fb_we;
  logic [7:0]  rx_byte;
  logic [2:0]  fb_row;
  logic [31:0] fb_data;

  uart_rx_row_loader #(
    .CLKS_PER_BIT(CLKS),
    .ROWS        (ROWS),
    .ROW_BYTES   (RB),
    .SYNC_BYTE   (SYNC)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .uart_data(uart_data),
    .rx_dv    (rx_dv),
    .rx_byte  (rx_byte),
    .rx_err   (rx_err),
    .fb_we    (fb_we),
    .fb_row   (fb_row),
    .fb_data  (fb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         err;
    logic [7:0] b;
    int         t0;
  } rx_ev_t;

  typedef struct {
    logic [2:0]  row;
    logic [31:0] data;
  } wr_t;

  rx_ev_t      rxq[$];
  wr_t         wq[$];
  logic [7:0]  pend[$];
  int          checks = 0;
  int          errors = 0;
  int          ev_seen = 0;
  logic [2:0]  last_row = '0;
  logic [31:0] last_data = '0;
  logic [7:0]  last_good = '0;
  rx_ev_t      mev;
  wr_t         mw;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Packet model: collect bytes after a sync, parse when complete.
  task automatic model_byte(input logic [7:0] b, input bit err);
    wr_t w;
    if (err) begin
      pend.delete();
      return;
    end
    if (pend.size() == 0) begin
      if (b == SYNC) pend.push_back(b);
      return;
    end
    if (pend.size() == 1) begin
      if (int'(b) < ROWS) pend.push_back(b);
      else pend.delete();
      return;
    end
    pend.push_back(b);
    if (pend.size() == 2 + RB) begin
      w.row = pend[1][2:0];
      for (int i = 0; i < RB; i++) w.data[8*i +: 8] = pend[2+i];
      wq.push_back(w);
      pend.delete();
    end
  endtask

  task automatic send_char(input logic [7:0] b, input bit bad_stop);
    rx_ev_t ev;
    @(negedge clk);
    ev.err = bad_stop;
    ev.b   = b;
    ev.t0  = cyc;
    rxq.push_back(ev);
    model_byte(b, bad_stop);
    uart_data = 1'b0;
    repeat (CLKS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_data = b[i];
      repeat (CLKS) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    uart_data = ^b;
    repeat (CLKS) @(negedge clk);
`endif
    uart_data = !bad_stop;
    repeat (CLKS) @(negedge clk);
    uart_data = 1'b1;
    if (bad_stop) repeat (2 * CLKS) @(negedge clk);
  endtask

  task automatic send_pkt(input logic [7:0] row, input logic [31:0] d,
                          input int bad_idx);
    logic [7:0] bytes[6];
    bytes[0] = SYNC;
    bytes[1] = row;
    for (int i = 0; i < 4; i++) bytes[2+i] = d[8*i +: 8];
    for (int i = 0; i < 6; i++) send_char(bytes[i], i == bad_idx);
  endtask

  task automatic check_hold();
    chk("fb_row_hold", 64'(fb_row), 64'(last_row));
    chk("fb_data_hold", 64'(fb_data), 64'(last_data));
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (rx_dv || rx_err) ev_seen++;
      if (rx_dv) begin
        if (rxq.size() == 0) begin
          chk("rx_dv_unexpected", 64'(rx_byte), 64'hx);
        end else begin
          mev = rxq.pop_front();
          chk("rx_dv_kind", 64'(rx_err), 64'(mev.err));
          chk("rx_byte", 64'(rx_byte), 64'(mev.b));
          chk("rx_dv_latency", 64'(cyc - mev.t0), 64'(LAT));
          last_good = mev.b;
        end
      end else if (rx_err) begin
        if (rxq.size() == 0) begin
          chk("rx_err_unexpected", 64'(rx_err), 64'd0);
        end else begin
          mev = rxq.pop_front();
          chk("rx_err_kind", 64'(1), 64'(mev.err));
          chk("rx_byte_on_err", 64'(rx_byte), 64'(last_good));
          chk("rx_err_latency", 64'(cyc - mev.t0), 64'(LAT));
        end
      end
      if (fb_we) begin
        if (wq.size() == 0) begin
          chk("fb_we_unexpected", 64'(fb_row), 64'hx);
        end else begin
          mw = wq.pop_front();
          chk("fb_row", 64'(fb_row), 64'(mw.row));
          chk("fb_data", 64'(fb_data), 64'(mw.data));
          last_row  = mw.row;
          last_data = mw.data;
        end
      end
    end
  end

  initial begin
    int seen0;
    reset     = 1'b1;
    uart_data = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("reset_outputs",
          64'({rx_dv, rx_err, fb_we, rx_byte, fb_row, fb_data}), 64'd0);
    end
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // single byte
    send_char(8'h3C, 1'b0);
    repeat (CLKS) @(negedge clk);

    // basic packet
    send_pkt(8'h03, 32'h44332211, -1);
    check_hold();

    // short glitch must not start a character
    seen0 = ev_seen;
    @(negedge clk);
    uart_data = 1'b0;
    repeat (8) @(negedge clk);
    uart_data = 1'b1;
    repeat (3 * CLKS) @(negedge clk);
    chk("glitch_events", 64'(ev_seen - seen0), 64'd0);

    // framing error on 2nd payload byte, then clean packet
    send_pkt(8'h05, 32'h0000BB66, 3);
    send_pkt(8'h01, 32'hDDCCBBAA, -1);
    check_hold();

    // out-of-range row, then a valid packet
    send_char(SYNC, 1'b0);
    send_char(8'h08, 1'b0);
    send_pkt(8'h07, 32'hA5A5A5A5, -1);
    check_hold();

    // reset in mid-payload discards the partial packet
    send_char(SYNC, 1'b0);
    send_char(8'h04, 1'b0);
    send_char(8'h12, 1'b0);
    send_char(8'h34, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    pend.delete();
    last_row  = '0;
    last_data = '0;
    last_good = '0;
    repeat (3) begin
      @(negedge clk);
      chk("midreset_outputs",
          64'({rx_dv, rx_err, fb_we, rx_byte, fb_row, fb_data}), 64'd0);
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    send_pkt(8'h04, 32'h9988_7766, -1);
    check_hold();

    // randomized traffic
    for (int n = 0; n < 12; n++) begin
      int kind;
      kind = $urandom_range(0, 5);
      if (kind == 0) begin
        send_char(8'($urandom), $urandom_range(0, 15) == 0);
      end else begin
        logic [7:0] r;
        r = 8'($urandom_range(0, 9));
        send_char(SYNC, 1'b0);
        send_char(r, $urandom_range(0, 15) == 0);
        for (int i = 0; i < RB; i++) begin
          send_char(8'($urandom), $urandom_range(0, 15) == 0);
          repeat ($urandom_range(0, 25)) @(negedge clk);
        end
      end
    end

    repeat (4 * CLKS) @(negedge clk);
    check_hold();
    chk("rx_queue_drained", 64'(rxq.size()), 64'd0);
    chk("wr_queue_drained", 64'(wq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
